ber_checker: RTL and testbench

Symbol-rate PRBS9 bit-error-rate checker: the receive-side consumer of the symbol-rate enable produced by the team's clock-enable divider. On every enable strobe it samples one received bit and self-synchronises to the PRBS9 sequence x^9+x^5+1. Once locked, it compares each received bit against a free-running local predictor and accumulates bit and error counts. It sits at the end of the receive chain, after decimation, and its counters are read by the control/VIO logic.

---
 rtl/ber_checker.sv | 157 +++++++++++++++
 tb/tb_ber_checker.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_checker.sv
// PRBS9 (x^9+x^5+1) bit-error-rate checker. Self-synchronises on the received
// stream, then free-runs a local predictor and accumulates bit/error counts.
module ber_checker #(
   parameter int COUNT_W     = 32,
   parameter int LOCK_COUNT  = 16,
   parameter int WINDOW      = 64,
   parameter int LOSS_THRESH = 8
) (
   input  logic               clock,
   input  logic               i_reset,
   input  logic               i_enable,
   input  logic               i_rx_bit,
   input  logic               i_clear,
   output logic               o_locked,
   output logic               o_err,
   output logic [COUNT_W-1:0] o_bit_count,
   output logic [COUNT_W-1:0] o_err_count
);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_SYNC,
      ST_LOCKED
   } state_e;

   state_e             state_q, state_d;
   logic [8:0]         sr_q, sr_d;
   logic [8:0]         sr_shift_rx;
   logic [3:0]         load_cnt_q, load_cnt_d;
   logic [7:0]         match_cnt_q, match_cnt_d;
   logic [15:0]        win_cnt_q, win_cnt_d;
   logic [15:0]        win_err_q, win_err_d;
   logic [16:0]        win_err_sum;
   logic [COUNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [COUNT_W-1:0] err_cnt_q, err_cnt_d;
   logic               locked_q, locked_d;
   logic               err_q, err_d;
   logic               pred;
   logic               mismatch;

   assign pred        = sr_q[8] ^ sr_q[4];
   assign mismatch    = i_rx_bit ^ pred;
   assign sr_shift_rx = {sr_q[7:0], i_rx_bit};
   // Includes the current bit so the window-ending enable counts its own error.
   assign win_err_sum = {1'b0, win_err_q} + {16'd0, mismatch};

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      load_cnt_d  = load_cnt_q;
      match_cnt_d = match_cnt_q;
      win_cnt_d   = win_cnt_q;
      win_err_d   = win_err_q;
      bit_cnt_d   = bit_cnt_q;
      err_cnt_d   = err_cnt_q;
      err_d       = 1'b0;

      if (i_enable) begin
         unique case (state_q)
            ST_LOAD: begin
               sr_d = sr_shift_rx;
               if (load_cnt_q == 4'd8) begin
                  load_cnt_d = 4'd0;
                  // An all-zero register would lock the PRBS up; refill instead.
                  if (sr_shift_rx != 9'd0) begin
                     state_d     = ST_SYNC;
                     match_cnt_d = 8'd0;
                  end
               end else begin
                  load_cnt_d = load_cnt_q + 4'd1;
               end
            end

            ST_SYNC: begin
               if (!mismatch) begin
                  sr_d        = sr_shift_rx;
                  match_cnt_d = match_cnt_q + 8'd1;
                  if (match_cnt_q + 8'd1 == 8'(LOCK_COUNT)) begin
                     state_d   = ST_LOCKED;
                     win_cnt_d = 16'd0;
                     win_err_d = 16'd0;
                  end
               end else begin
                  state_d    = ST_LOAD;
                  load_cnt_d = 4'd0;
               end
            end

            ST_LOCKED: begin
               sr_d  = {sr_q[7:0], pred};
               err_d = mismatch;
               if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + COUNT_W'(1);
               if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + COUNT_W'(1);

               if (win_cnt_q == 16'(WINDOW - 1)) begin
                  if (win_err_sum >= 17'(LOSS_THRESH)) begin
                     state_d    = ST_LOAD;
                     load_cnt_d = 4'd0;
                  end else begin
                     win_cnt_d = 16'd0;
                     win_err_d = 16'd0;
                  end
               end else begin
                  win_cnt_d = win_cnt_q + 16'd1;
                  win_err_d = win_err_sum[15:0];
               end
            end

            default: begin
               state_d    = ST_LOAD;
               load_cnt_d = 4'd0;
            end
         endcase
      end

      if (i_clear) begin
         bit_cnt_d = '0;
         err_cnt_d = '0;
      end

      locked_d = (state_d == ST_LOCKED);
   end

   // NOTE: state registers use non-blocking assignment so all flops update together.
   always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= ST_LOAD;
         sr_q        <= 9'd0;
         load_cnt_q  <= 4'd0;
         match_cnt_q <= 8'd0;
         win_cnt_q   <= 16'd0;
         win_err_q   <= 16'd0;
         bit_cnt_q   <= '0;
         err_cnt_q   <= '0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         load_cnt_q  <= load_cnt_d;
         match_cnt_q <= match_cnt_d;
         win_cnt_q   <= win_cnt_d;
         win_err_q   <= win_err_d;
         bit_cnt_q   <= bit_cnt_d;
         err_cnt_q   <= err_cnt_d;
         locked_q    <= locked_d;
         err_q       <= err_d;
      end
   end

   assign o_locked    = locked_q;
   assign o_err       = err_q;
   assign o_bit_count = bit_cnt_q;
   assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_ber_checker.sv
// Scoreboard bench for ber_checker: a 32-bit and a 4-bit-counter instance share
// one PRBS9 stimulus; a behavioural model queues expectations per enable.
module tb_ber_checker;

   localparam int LOCK = 16;
   localparam int WIN  = 64;
   localparam int THR  = 8;

   logic        clock = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_enable = 1'b0;
   logic        i_rx_bit = 1'b0;
   logic        i_clear = 1'b0;
   logic        o_locked, o_err;
   logic [31:0] o_bit_count, o_err_count;
   logic        locked_s, err_s;
   logic [3:0]  bits_s, errs_s;

   always #5 clock = ~clock;

   ber_checker #(.COUNT_W(32), .LOCK_COUNT(LOCK), .WINDOW(WIN), .LOSS_THRESH(THR)) dut (
      .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_rx_bit(i_rx_bit),
      .i_clear(i_clear), .o_locked(o_locked), .o_err(o_err),
      .o_bit_count(o_bit_count), .o_err_count(o_err_count));

   ber_checker #(.COUNT_W(4), .LOCK_COUNT(LOCK), .WINDOW(WIN), .LOSS_THRESH(THR)) dut_s (
      .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_rx_bit(i_rx_bit),
      .i_clear(i_clear), .o_locked(locked_s), .o_err(err_s),
      .o_bit_count(bits_s), .o_err_count(errs_s));

   int n_cmp = 0;
   int n_bad = 0;
   int err_pulses = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
      end
   endtask

   // ---------------- behavioural model and scoreboard ----------------
   typedef enum {M_LOAD, M_SYNC, M_LOCKED} mstate_e;
   typedef struct {
      logic        locked;
      logic        err;
      logic [31:0] bits;
      logic [31:0] errs;
      logic [3:0]  bits_s;
      logic [3:0]  errs_s;
   } exp_t;

   exp_t        exp_q[$];
   mstate_e     m_state;
   logic [8:0]  m_sr;
   int          m_load, m_match, m_win, m_werr;
   logic [31:0] m_bits, m_errs;
   logic [3:0]  m_bits_s, m_errs_s;

   task automatic model_reset();
      m_state = M_LOAD;
      m_sr = 9'd0;
      m_load = 0; m_match = 0; m_win = 0; m_werr = 0;
      m_bits = 0; m_errs = 0; m_bits_s = 0; m_errs_s = 0;
   endtask

   task automatic model_step(input logic rx, input logic clr);
      exp_t e;
      logic p, miss;
      p = m_sr[8] ^ m_sr[4];
      miss = (rx != p);
      e.err = 1'b0;
      case (m_state)
         M_LOAD: begin
            m_sr = {m_sr[7:0], rx};
            m_load++;
            if (m_load == 9) begin
               if (m_sr == 9'd0) m_load = 0;
               else begin m_state = M_SYNC; m_match = 0; end
            end
         end
         M_SYNC: begin
            if (!miss) begin
               m_sr = {m_sr[7:0], rx};
               m_match++;
               if (m_match == LOCK) begin m_state = M_LOCKED; m_win = 0; m_werr = 0; end
            end else begin
               m_state = M_LOAD; m_load = 0;
            end
         end
         default: begin
            m_sr = {m_sr[7:0], p};
            e.err = miss;
            if (m_bits != 32'hFFFF_FFFF) m_bits++;
            if (m_bits_s != 4'hF) m_bits_s++;
            if (miss && m_errs != 32'hFFFF_FFFF) m_errs++;
            if (miss && m_errs_s != 4'hF) m_errs_s++;
            m_win++;
            if (miss) m_werr++;
            if (m_win == WIN) begin
               if (m_werr >= THR) begin m_state = M_LOAD; m_load = 0; end
               else begin m_win = 0; m_werr = 0; end
            end
         end
      endcase
      if (clr) begin m_bits = 0; m_errs = 0; m_bits_s = 0; m_errs_s = 0; end
      e.locked = (m_state == M_LOCKED);
      e.bits = m_bits; e.errs = m_errs; e.bits_s = m_bits_s; e.errs_s = m_errs_s;
      exp_q.push_back(e);
   endtask

   logic mon_en;
   exp_t mon_e;
   always @(posedge clock) begin
      mon_en = i_enable;
      #1;
      if (i_reset) begin
         if (mon_en) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("sb_locked",   32'(o_locked),    32'(mon_e.locked));
               check("sb_err",      32'(o_err),       32'(mon_e.err));
               check("sb_bits",     o_bit_count,      mon_e.bits);
               check("sb_errs",     o_err_count,      mon_e.errs);
               check("sb_locked_s", 32'(locked_s),    32'(mon_e.locked));
               check("sb_bits_s",   32'(bits_s),      32'(mon_e.bits_s));
               check("sb_errs_s",   32'(errs_s),      32'(mon_e.errs_s));
            end
         end else begin
            check("err_idle", 32'(o_err), 32'd0);
         end
         if (o_err) err_pulses++;
      end
   end

   // ---------------- stimulus ----------------
   logic [8:0] g;

   function automatic logic gen_next();
      logic b;
      b = g[8] ^ g[4];
      g = {g[7:0], b};
      return b;
   endfunction

   // Called at a falling edge; returns at the falling edge after the sampling edge.
   task automatic send(input logic rx, input logic clr);
      i_enable = 1'b1;
      i_rx_bit = rx;
      i_clear  = clr;
      model_step(rx, clr);
      @(negedge clock);
      i_enable = 1'b0;
      i_clear  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send4(input logic rx);
      send(rx, 1'b0);
      idle(3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int   p0, n_align, mism;
      logic b, r;

      g = 9'h1FF;
      model_reset();
      idle(3);
      check("rst_locked", 32'(o_locked), 32'd0);
      check("rst_err",    32'(o_err),    32'd0);
      check("rst_bits",   o_bit_count,   32'd0);
      check("rst_errs",   o_err_count,   32'd0);
      i_reset = 1'b1;
      idle(2);

      // Clean lock: 9 loads plus LOCK matches.
      for (int i = 0; i < 25; i++) begin
         send4(gen_next());
         if (i == 23) check("lock_not_yet", 32'(o_locked), 32'd0);
      end
      check("lock_at_25", 32'(o_locked), 32'd1);

      p0 = err_pulses;
      for (int i = 0; i < 100; i++) begin
         send4(gen_next());
         if (i == 19) check("sat_bits_20", 32'(bits_s), 32'd15);
      end
      check("clean_bits_100", o_bit_count, 32'd100);
      check("clean_errs_0",   o_err_count, 32'd0);
      check("clean_no_pulse", 32'(err_pulses - p0), 32'd0);

      // Single error while locked; predictor keeps free-running afterwards.
      p0 = err_pulses;
      send4(~gen_next());
      for (int i = 0; i < 10; i++) send4(gen_next());
      check("single_pulses", 32'(err_pulses - p0), 32'd1);
      check("single_errs",   o_err_count,           32'd1);
      check("single_locked", 32'(o_locked),         32'd1);

      // Clear coincident with an erroneous locked enable.
      send(~gen_next(), 1'b1);
      check("clr_err_pulse", 32'(o_err),     32'd1);
      check("clr_bits",      o_bit_count,    32'd0);
      check("clr_errs",      o_err_count,    32'd0);
      check("clr_bits_s",    32'(bits_s),    32'd0);
      check("clr_errs_s",    32'(errs_s),    32'd0);
      idle(3);

      // Back-to-back enables.
      for (int i = 0; i < 20; i++) send(gen_next(), 1'b0);
      idle(3);
      check("b2b_bits", o_bit_count, 32'd20);

      // Align to a window boundary, then a full window of random data.
      n_align = 0;
      while (m_win != 0 && n_align < WIN) begin
         send4(gen_next());
         n_align++;
      end
      mism = 0;
      for (int i = 0; i < WIN; i++) begin
         b = gen_next();
         r = 1'($urandom_range(0, 1));
         if (r != b) mism++;
         send4(r);
         if (i == WIN - 2) check("loss_still_locked", 32'(o_locked), 32'd1);
      end
      check("loss_dropped",   32'(o_locked), 32'd0);
      check("loss_err_count", o_err_count,   32'(mism));
      for (int i = 0; i < 5; i++) send4(gen_next());
      check("retain_bits", o_bit_count, 32'(20 + n_align + WIN));
      check("retain_errs", o_err_count, 32'(mism));

      // Asynchronous reset mid-stream, checked before any further clock edge.
      i_reset = 1'b0;
      #1;
      check("arst_locked", 32'(o_locked), 32'd0);
      check("arst_err",    32'(o_err),    32'd0);
      check("arst_bits",   o_bit_count,   32'd0);
      check("arst_errs",   o_err_count,   32'd0);
      check("arst_bits_s", 32'(bits_s),   32'd0);
      idle(2);
      model_reset();
      i_reset = 1'b1;
      idle(1);

      // Error during SYNC: relock 25 enables after the corrupted bit.
      for (int i = 0; i < 40; i++) begin
         b = gen_next();
         send4((i == 14) ? ~b : b);
         if (i == 14) check("sync_err_unlocked", 32'(o_locked), 32'd0);
         if (i == 38) check("sync_relock_not_yet", 32'(o_locked), 32'd0);
      end
      check("sync_relock", 32'(o_locked), 32'd1);

      idle(2);
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
